// File: rtl/cmsdk_mcu_altfunc_switch_ctrl.sv
// Serialises alternate-function changes on shared pins: wait for peripheral idle,
// tristate for a guard time, flip the mux select, hold tristate again, release.
module cmsdk_mcu_altfunc_switch_ctrl #(
  parameter int unsigned    NCH          = 3,
  parameter int unsigned    GUARD_CYCLES = 4,
  parameter int unsigned    CNT_W        = 4,
  parameter logic [NCH-1:0] RESET_SEL    = '0
) (
  input  logic           HCLK,
  input  logic           HRESET,
  input  logic [NCH-1:0] altfunc_req,
  input  logic [NCH-1:0] periph_busy,
  output logic [NCH-1:0] altfunc_sel,
  output logic [NCH-1:0] oe_block,
  output logic           switch_active,
  output logic [NCH-1:0] switch_done
);

  localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_IDLE  = 2'd1;
  localparam logic [1:0] ST_GUARD_PRE  = 2'd2;
  localparam logic [1:0] ST_GUARD_POST = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ch_q, ch_d;
  logic [PTR_W-1:0] rr_q, rr_d;
  logic             tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   sel_q, sel_d;
  logic [NCH-1:0]   oe_q, oe_d;
  logic [NCH-1:0]   done_q, done_d;
  logic             active_q, active_d;

  logic [NCH-1:0]   pending;
  logic             grant_vld;
  logic [PTR_W-1:0] grant_ch;
  int unsigned      arb_idx;
  logic             withdrawn;

  assign pending   = altfunc_req ^ sel_q;
  assign withdrawn = (altfunc_req[ch_q] == sel_q[ch_q]);

  // Round-robin search starting at rr_q for the first pending channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    arb_idx   = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      arb_idx = (32'(rr_q) + k) % NCH;
      if (!grant_vld && pending[PTR_W'(arb_idx)]) begin
        grant_vld = 1'b1;
        grant_ch  = PTR_W'(arb_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    oe_d    = oe_q;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          ch_d    = grant_ch;
          tgt_d   = altfunc_req[grant_ch];
          rr_d    = PTR_W'((32'(grant_ch) + 1) % NCH);
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (withdrawn) begin
          state_d = ST_IDLE;
        end else if (!(tgt_q == 1'b0 && periph_busy[ch_q])) begin
          oe_d[ch_q] = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = ST_GUARD_PRE;
        end
      end
      ST_GUARD_PRE: begin
        if (withdrawn) begin
          oe_d[ch_q] = 1'b0;
          state_d    = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          sel_d[ch_q] = tgt_q;
          cnt_d       = CNT_LOAD;
          state_d     = ST_GUARD_POST;
        end
      end
      ST_GUARD_POST: begin
        // Target is committed here; request changes are re-arbitrated afterwards.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          oe_d[ch_q]   = 1'b0;
          done_d[ch_q] = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      rr_q     <= '0;
      tgt_q    <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= RESET_SEL;
      oe_q     <= '0;
      done_q   <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      rr_q     <= rr_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign altfunc_sel   = sel_q;
  assign oe_block      = oe_q;
  assign switch_done   = done_q;
  assign switch_active = active_q;

endmodule

// File: tb/tb_cmsdk_mcu_altfunc_switch_ctrl.sv
// Scoreboard bench for the altfunc switch sequencer: expected done events are queued
// at stimulus time and matched against switch_done pulses by a negedge monitor.
module tb_cmsdk_mcu_altfunc_switch_ctrl;

  localparam int unsigned NCH = 3;
  localparam int unsigned G   = 4;

  typedef struct {
    logic [NCH-1:0] done;
    logic [NCH-1:0] sel;
    int             cyc;
  } exp_t;

  logic           HCLK = 1'b0;
  logic           HRESET = 1'b1;
  logic [NCH-1:0] altfunc_req = '0;
  logic [NCH-1:0] periph_busy = '0;
  logic [NCH-1:0] altfunc_sel;
  logic [NCH-1:0] oe_block;
  logic           switch_active;
  logic [NCH-1:0] switch_done;

  int             n_checks = 0;
  int             n_fail   = 0;
  int             cyc      = 0;
  int             c;
  int             m;
  exp_t           sb[$];
  exp_t           e;
  logic           mon_en   = 1'b0;
  logic           rst_edge = 1'b1;
  logic [NCH-1:0] sel_prev = '0;

  cmsdk_mcu_altfunc_switch_ctrl #(
    .NCH(NCH), .GUARD_CYCLES(G), .CNT_W(4), .RESET_SEL(3'b000)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .altfunc_req(altfunc_req), .periph_busy(periph_busy),
    .altfunc_sel(altfunc_sel), .oe_block(oe_block), .switch_active(switch_active),
    .switch_done(switch_done)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    cyc      <= cyc + 1;
    rst_edge <= HRESET;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET      = 1'b1;
    altfunc_req = '0;
    periph_busy = '0;
    step();
    step();
    HRESET = 1'b0;
  endtask

  task automatic push_exp(input logic [NCH-1:0] d, input logic [NCH-1:0] s, input int at);
    exp_t x;
    x.done = d;
    x.sel  = s;
    x.cyc  = at;
    sb.push_back(x);
  endtask

  // Done pulses are matched in order; oe exclusivity and sel-under-oe checked every cycle.
  always @(negedge HCLK) begin
    if (mon_en) begin
      if (switch_done !== '0) begin
        if (sb.size() == 0) begin
          check_eq("done_unexpected", 32'(switch_done), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("done_vec", 32'(switch_done), 32'(e.done));
          check_eq("done_sel", 32'(altfunc_sel), 32'(e.sel));
          check_eq("done_cyc", 32'(cyc), 32'(e.cyc));
        end
      end
      check_eq("oe_onehot", 32'($countones(oe_block) <= 1), 32'd1);
      if (!rst_edge && altfunc_sel != sel_prev)
        check_eq("sel_under_oe", 32'((altfunc_sel ^ sel_prev) & ~oe_block), 32'd0);
      sel_prev = altfunc_sel;
    end
  end

  initial begin
    do_reset();
    @(negedge HCLK);
    check_eq("rst_sel", 32'(altfunc_sel), 32'd0);
    check_eq("rst_oe", 32'(oe_block), 32'd0);
    check_eq("rst_done", 32'(switch_done), 32'd0);
    check_eq("rst_active", 32'(switch_active), 32'd0);
    sel_prev = altfunc_sel;
    mon_en   = 1'b1;

    // Single GPIO->alt switch on ch0 with exact timing.
    step();
    c = cyc;
    altfunc_req = 3'b001;
    push_exp(3'b001, 3'b001, c + 2 * G + 2);
    for (int k = 1; k <= 2 * G + 2; k++) begin
      step();
      @(negedge HCLK);
      check_eq("t1_oe", 32'(oe_block), (k >= 2 && k <= 2 * G + 1) ? 32'd1 : 32'd0);
      check_eq("t1_sel0", 32'(altfunc_sel[0]), (k >= G + 2) ? 32'd1 : 32'd0);
    end
    check_eq("t1_active", 32'(switch_active), 32'd0);

    // All three requested together: round-robin order ch0, ch1, ch2.
    do_reset();
    c = cyc;
    altfunc_req = 3'b111;
    push_exp(3'b001, 3'b001, c + 2 * G + 2);
    push_exp(3'b010, 3'b011, c + 4 * G + 4);
    push_exp(3'b100, 3'b111, c + 6 * G + 6);
    repeat (6 * G + 10) step();
    check_eq("t2_sb_drained", 32'(sb.size()), 32'd0);
    check_eq("t2_sel", 32'(altfunc_sel), 32'b111);

    // alt->GPIO on ch1 held off by periph_busy.
    c = cyc;
    periph_busy = 3'b010;
    altfunc_req = 3'b101;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge HCLK);
      check_eq("t3_hold_oe", 32'(oe_block), 32'd0);
      check_eq("t3_hold_active", 32'(switch_active), 32'd1);
      check_eq("t3_hold_sel", 32'(altfunc_sel), 32'b111);
    end
    m = cyc;
    periph_busy = 3'b000;
    push_exp(3'b010, 3'b101, m + 2 * G + 1);
    for (int k = 1; k <= 2 * G + 2; k++) begin
      step();
      @(negedge HCLK);
      check_eq("t3_oe", 32'(oe_block), (k <= 2 * G) ? 32'b010 : 32'd0);
      check_eq("t3_sel1", 32'(altfunc_sel[1]), (k >= G + 1) ? 32'd0 : 32'd1);
    end

    // Request withdrawn during the second GUARD_PRE cycle.
    do_reset();
    altfunc_req = 3'b100;
    step();
    step();
    @(negedge HCLK);
    check_eq("t4_oe_pre1", 32'(oe_block), 32'b100);
    step();
    @(negedge HCLK);
    check_eq("t4_oe_pre2", 32'(oe_block), 32'b100);
    altfunc_req = 3'b000;
    step();
    @(negedge HCLK);
    check_eq("t4_oe_clr", 32'(oe_block), 32'd0);
    check_eq("t4_active", 32'(switch_active), 32'd0);
    check_eq("t4_sel", 32'(altfunc_sel), 32'd0);
    for (int k = 0; k < 2 * G; k++) begin
      step();
      @(negedge HCLK);
      check_eq("t4_no_done", 32'(switch_done), 32'd0);
    end

    // Request toggled during GUARD_POST: latched target completes, then a reverse switch.
    c = cyc;
    altfunc_req = 3'b001;
    push_exp(3'b001, 3'b001, c + 2 * G + 2);
    push_exp(3'b001, 3'b000, c + 4 * G + 4);
    repeat (G + 3) step();
    altfunc_req = 3'b000;
    repeat (3 * G + 4) step();
    check_eq("t5_sb_drained", 32'(sb.size()), 32'd0);
    check_eq("t5_sel", 32'(altfunc_sel), 32'd0);

    // Reset during GUARD_POST of ch1 aborts immediately.
    c = cyc;
    altfunc_req = 3'b010;
    repeat (G + 3) step();
    @(negedge HCLK);
    check_eq("t6_pre_sel", 32'(altfunc_sel), 32'b010);
    check_eq("t6_pre_oe", 32'(oe_block), 32'b010);
    HRESET      = 1'b1;
    altfunc_req = 3'b000;
    step();
    HRESET = 1'b0;
    @(negedge HCLK);
    check_eq("t6_sel", 32'(altfunc_sel), 32'd0);
    check_eq("t6_oe", 32'(oe_block), 32'd0);
    check_eq("t6_active", 32'(switch_active), 32'd0);
    check_eq("t6_done", 32'(switch_done), 32'd0);
    repeat (2 * G + 4) step();
    @(negedge HCLK);
    check_eq("t6_idle_active", 32'(switch_active), 32'd0);
    check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
